bus_xfer_ctrl: RTL

- Sequencer directly upstream of the bank of general-purpose registers.
- Accepts one register-transfer command at a time (src -> dst, or immediate -> dst) over a valid/ready handshake.
- Generates the per-register out_en / load_en strobes and the immediate-driver strobe so exactly one source drives the shared 8-bit bus while the destination captures it.
- Guarantees no bus contention and no spurious loads.

---
 rtl/bus_xfer_ctrl_pkg.sv | 26 ++
 rtl/bus_xfer_ctrl_if.sv | 37 +++
 rtl/bus_xfer_ctrl_onehot_dec.sv | 21 ++
 rtl/bus_xfer_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/bus_xfer_ctrl_pkg.sv
// bus_xfer_ctrl_pkg
//   Shared definitions for the register-transfer sequencer: FSM state
//   encodings, default widths and the command legality check.
package bus_xfer_ctrl_pkg;

  localparam int DEF_NREG   = 4;
  localparam int DEF_SEL_W  = 3;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_LOAD  = 2'b10
  } state_t;

  // A command is legal when the destination exists and, for a register
  // move, the source exists and differs from the destination.
  function automatic logic cmd_ok(input logic imm, input int unsigned src,
                                  input int unsigned dst, input int unsigned nreg);
    logic ok;
    ok = (dst < nreg);
    if (!imm) ok = ok && (src < nreg) && (src != dst);
    return ok;
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// bus_xfer_ctrl_if
//   Command handshake plus register-bank strobe bundle.
//   Handshake: a command transfers on a rising clk edge where
//   req_valid && req_ready are both high. req_ready is high only while the
//   controller is IDLE; req_* are don't-care whenever req_valid is low, and
//   req_* changes while req_ready is low have no effect.
//   modport slave  : controller side (bus_xfer_ctrl)
//   modport master : command issuer / register-bank side
interface bus_xfer_ctrl_if #(
  parameter int NREG   = 4,
  parameter int SEL_W  = 3,
  parameter int DATA_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_imm;
  logic [SEL_W-1:0]  req_src;
  logic [SEL_W-1:0]  req_dst;
  logic [DATA_W-1:0] req_data;
  logic [NREG-1:0]   out_en;
  logic [NREG-1:0]   load_en;
  logic              imm_oe;
  logic [DATA_W-1:0] imm_bus;
  logic              done;
  logic              err;
  logic              busy;

  modport slave (
    input  req_valid, req_imm, req_src, req_dst, req_data,
    output req_ready, out_en, load_en, imm_oe, imm_bus, done, err, busy
  );

  modport master (
    output req_valid, req_imm, req_src, req_dst, req_data,
    input  req_ready, out_en, load_en, imm_oe, imm_bus, done, err, busy
  );
endinterface

// File: rtl/bus_xfer_ctrl_onehot_dec.sv
// onehot_dec
//   Index-to-one-hot decoder with enable.
//   idx : register index
//   en  : decode enable
//   oh  : one-hot result; all zero when en=0 or idx >= NREG
module onehot_dec #(
  parameter int SEL_W = 3,
  parameter int NREG  = 4
) (
  input  logic [SEL_W-1:0] idx,
  input  logic             en,
  output logic [NREG-1:0]  oh
);
  // Out-of-range indices match no bit position, so they decode to zero.
  always_comb begin
    oh = '0;
    for (int i = 0; i < NREG; i++) begin
      oh[i] = en && (idx == SEL_W'(i));
    end
  end
endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl
//   Sequences one register transfer at a time onto a shared bus:
//   DRIVE (source enabled, bus settles) -> LOAD (source held, destination
//   loads) -> IDLE with a one-cycle done pulse. Illegal commands produce a
//   one-cycle err pulse and no enables.
//   clk       : rising-edge clock shared with the register bank
//   reset_n   : asynchronous active-low reset
//   bus       : command handshake and strobe outputs (slave modport)
//   dbg_state : current FSM state
module bus_xfer_ctrl
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int NREG   = DEF_NREG,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic             clk,
  input  logic             reset_n,
  bus_xfer_ctrl_if.slave   bus,
  output state_t           dbg_state
);

  state_t            state;
  logic              rst_done;   // low until the first edge after reset release
  logic [NREG-1:0]   out_en_q;
  logic [NREG-1:0]   load_en_q;
  logic [NREG-1:0]   dst_oh_q;   // latched destination, applied in LOAD
  logic              imm_oe_q;
  logic [DATA_W-1:0] imm_bus_q;
  logic              done_q;
  logic              err_q;
  logic              busy_q;

  logic [NREG-1:0]   src_oh;
  logic [NREG-1:0]   dst_oh;
  logic              req_ready_w;
  logic              accept;
  logic              legal;

  onehot_dec #(.SEL_W(SEL_W), .NREG(NREG)) u_src_dec (
    .idx (bus.req_src),
    .en  (!bus.req_imm),
    .oh  (src_oh)
  );

  onehot_dec #(.SEL_W(SEL_W), .NREG(NREG)) u_dst_dec (
    .idx (bus.req_dst),
    .en  (1'b1),
    .oh  (dst_oh)
  );

  assign req_ready_w = rst_done && (state == ST_IDLE);
  assign accept      = bus.req_valid && req_ready_w;
  assign legal       = cmd_ok(bus.req_imm, 32'(bus.req_src), 32'(bus.req_dst), NREG);

  // Enables are decoded from the request at acceptance and registered, so
  // every strobe is a flop output and cannot glitch onto the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rst_done  <= 1'b0;
      out_en_q  <= '0;
      load_en_q <= '0;
      dst_oh_q  <= '0;
      imm_oe_q  <= 1'b0;
      imm_bus_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (legal) begin
              state     <= ST_DRIVE;
              busy_q    <= 1'b1;
              out_en_q  <= src_oh;
              imm_oe_q  <= bus.req_imm;
              imm_bus_q <= bus.req_imm ? bus.req_data : '0;
              dst_oh_q  <= dst_oh;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          // Source has had a full cycle to settle; open the destination.
          state     <= ST_LOAD;
          load_en_q <= dst_oh_q;
        end
        ST_LOAD: begin
          // Destination captures on this edge; release everything together.
          state     <= ST_IDLE;
          busy_q    <= 1'b0;
          out_en_q  <= '0;
          load_en_q <= '0;
          imm_oe_q  <= 1'b0;
          imm_bus_q <= '0;
          done_q    <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          busy_q    <= 1'b0;
          out_en_q  <= '0;
          load_en_q <= '0;
          imm_oe_q  <= 1'b0;
          imm_bus_q <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_w;
  assign bus.out_en    = out_en_q;
  assign bus.load_en   = load_en_q;
  assign bus.imm_oe    = imm_oe_q;
  assign bus.imm_bus   = imm_bus_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign dbg_state     = state;

endmodule
